wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Parametrised N-to-1 pipelined Wishbone arbiter that shares one master bus among `NUM_PORTS` requesters (instruction fetch, load/store, debug) in front of the external memory port. It generalises the two-port memory mux with:

- a selectable fixed-priority or round-robin policy,
- a registered grant held for a whole bus cycle,
- an outstanding-transaction counter that bounds in-flight requests.

## Interface
Parameters:
- `NUM_PORTS`, 2, number of slave ports (2..8).
- `ARB_MODE`, `ARB_FIXED`, `ARB_FIXED` (lowest index wins) or `ARB_RR` (round-robin).
- `MAX_OUTSTANDING`, 4, maximum accepted-but-unacknowledged requests (1..15).

Ports (clock and reset first; one clock, `clk_i`; reset `rst_i` is synchronous and active-high):
- `clk_i`  in  1  clock.
- `rst_i`  in  1  synchronous active-high reset.
- `s_wb_adr_i`  in  `[NUM_PORTS][32]`  slave addresses.
- `s_wb_dat_i`  in  `[NUM_PORTS][32]`  slave write data.
- `s_wb_dat_o`  out  `[NUM_PORTS][32]`  read data; zero unless granted.
- `s_wb_we_i`  in  `[NUM_PORTS]`  write enables.
- `s_wb_sel_i`  in  `[NUM_PORTS][4]`  byte selects.
- `s_wb_stb_i`  in  `[NUM_PORTS]`  strobes.
- `s_wb_cyc_i`  in  `[NUM_PORTS]`  cycle signals.
- `s_wb_ack_o`  out  `[NUM_PORTS]`  acks; zero unless granted.
- `s_wb_stall_o`  out  `[NUM_PORTS]`  stalls.
- `m_wb_adr_o`, `m_wb_dat_o`, `m_wb_we_o`, `m_wb_sel_o`, `m_wb_stb_o`, `m_wb_cyc_o`  out  32/32/1/4/1/1  master request.
- `m_wb_dat_i`, `m_wb_ack_i`, `m_wb_stall_i`  in  32/1/1  master response.

## Operation
- Request on port i: `req[i] = s_wb_cyc_i[i] & s_wb_stb_i[i]`.
- FSM states:
  - IDLE
    - All `s_wb_stall_o` = 1.
    - `m_wb_cyc_o` = 0, `m_wb_stb_o` = 0.
    - If any `req`: latch `grant_q` = picker result, go to BUSY.
  - BUSY
    - Master request outputs mirror port `grant_q`.
    - `m_wb_stb_o = s_wb_stb_i[g] & (cnt_q < MAX_OUTSTANDING)`.
    - `m_wb_cyc_o = s_wb_cyc_i[g]`.
    - `s_wb_stall_o[g] = m_wb_stall_i | (cnt_q == MAX_OUTSTANDING)`; all other ports stall = 1.
    - `s_wb_ack_o[g] = m_wb_ack_i` and `s_wb_dat_o[g] = m_wb_dat_i`; all other ports 0.
    - When `s_wb_cyc_i[g]` = 0: go to IDLE, clear `cnt_q`. In `ARB_RR`, set `rr_ptr_q = g+1` (mod `NUM_PORTS`).
- Picker:
  - `ARB_FIXED`: lowest-index asserted `req`.
  - `ARB_RR`: first asserted `req` at or after `rr_ptr_q`, wrapping.
- Outstanding counter `cnt_q`, width `$clog2(MAX_OUTSTANDING+1)`:
  - +1 on accept (`m_wb_stb_o & ~m_wb_stall_i`).
  - -1 on `m_wb_ack_i` while BUSY.
  - Both in the same cycle: unchanged.
  - Never exceeds `MAX_OUTSTANDING`, because the strobe is gated at the limit.
  - An ack with `cnt_q` = 0 is ignored (no underflow).
- Cycle abort (cyc dropped with `cnt_q` > 0): counter cleared; late acks after release are dropped.

## Timing
- Reset values:
  - FSM = IDLE, `grant_q` = 0, `rr_ptr_q` = 0, `cnt_q` = 0.
  - `m_wb_cyc_o` = `m_wb_stb_o` = 0.
  - All `s_wb_stall_o` = 1, all acks 0, all read data 0.
- Grant latency:
  - Request seen in IDLE at cycle N.
  - `m_wb_cyc_o`/`m_wb_stb_o` and granted stall deassertion are visible at N+1.
- Release:
  - Cyc low at cycle M → IDLE at M+1. At least one idle cycle separates consecutive grants.
  - An ack coincident with cyc falling is still forwarded at M.
- Reset mid-BUSY: returns to the reset state next edge, outstanding transactions discarded.
- Grant is never changed while BUSY, regardless of other requests.

## Structure
- `ecap5_dproc_pkg` gains `ARB_FIXED` = 0 and `ARB_RR` = 1 constants, plus a `arb_state_t` enum {`ARB_IDLE`, `ARB_BUSY`}.
- One sub-module `wb_arbiter_picker`:
  - Parametrised `NUM_PORTS`.
  - Inputs: `req`, `rr_ptr`, `mode`.
  - Output: one-hot-free index, combinational.
- Counter, FSM and muxes stay in `wb_arbiter`.

## Test plan
- Reset: hold `rst_i` 2 cycles with all `req` high → `m_wb_cyc_o` = 0 and all stalls = 1 during reset; grant to port 0 one cycle after release.
- Fixed priority, `NUM_PORTS` = 3: ports 1 and 2 request together → port 1 granted. Port 2 stalls until port 1 drops cyc, then granted 2 cycles later.
- Round-robin, 3 ports all continuously requesting with single-beat cycles → grant order 0,1,2,0,1,2.
- Outstanding limit, `MAX_OUTSTANDING` = 2, `m_wb_stall_i` = 0, acks withheld: third strobe blocked. Granted stall = 1 and `m_wb_stb_o` = 0 until one ack; then a third accept occurs.
- Read data routing: port 1 granted, `m_wb_dat_i` = 32'hDEADBEEF with ack → `s_wb_dat_o[1]` = DEADBEEF, others 0, `s_wb_ack_o` = 3'b010.
- Abort: cyc dropped with `cnt_q` = 2 → IDLE next cycle, `cnt_q` = 0. A subsequent stray `m_wb_ack_i` produces no slave ack.

Source files
------------

// File: rtl/ecap5_dproc_pkg.sv
// rtl/ecap5_dproc_pkg.sv - shared arbitration constants, FSM state type and helpers
package ecap5_dproc_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_t;

  function automatic int wrap_idx(int base, int off, int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// rtl/wb_arbiter_if.sv - N slave ports plus one master port of the Wishbone arbiter
interface wb_arbiter_if #(
  parameter int NUM_PORTS = 2
);
  logic [NUM_PORTS-1:0][31:0] s_wb_adr_i;
  logic [NUM_PORTS-1:0][31:0] s_wb_dat_i;
  logic [NUM_PORTS-1:0][31:0] s_wb_dat_o;
  logic [NUM_PORTS-1:0]       s_wb_we_i;
  logic [NUM_PORTS-1:0][3:0]  s_wb_sel_i;
  logic [NUM_PORTS-1:0]       s_wb_stb_i;
  logic [NUM_PORTS-1:0]       s_wb_cyc_i;
  logic [NUM_PORTS-1:0]       s_wb_ack_o;
  logic [NUM_PORTS-1:0]       s_wb_stall_o;

  logic [31:0] m_wb_adr_o;
  logic [31:0] m_wb_dat_o;
  logic        m_wb_we_o;
  logic [3:0]  m_wb_sel_o;
  logic        m_wb_stb_o;
  logic        m_wb_cyc_o;
  logic [31:0] m_wb_dat_i;
  logic        m_wb_ack_i;
  logic        m_wb_stall_i;

  // The arbiter itself connects through the slave view.
  modport slave (
    input  s_wb_adr_i, s_wb_dat_i, s_wb_we_i, s_wb_sel_i, s_wb_stb_i, s_wb_cyc_i,
    output s_wb_dat_o, s_wb_ack_o, s_wb_stall_o,
    output m_wb_adr_o, m_wb_dat_o, m_wb_we_o, m_wb_sel_o, m_wb_stb_o, m_wb_cyc_o,
    input  m_wb_dat_i, m_wb_ack_i, m_wb_stall_i
  );

  modport master (
    output s_wb_adr_i, s_wb_dat_i, s_wb_we_i, s_wb_sel_i, s_wb_stb_i, s_wb_cyc_i,
    input  s_wb_dat_o, s_wb_ack_o, s_wb_stall_o,
    input  m_wb_adr_o, m_wb_dat_o, m_wb_we_o, m_wb_sel_o, m_wb_stb_o, m_wb_cyc_o,
    output m_wb_dat_i, m_wb_ack_i, m_wb_stall_i
  );

endinterface

// File: rtl/wb_arbiter_picker.sv
// rtl/wb_arbiter_picker.sv - combinational request picker, fixed priority or round-robin
module wb_arbiter_picker
  import ecap5_dproc_pkg::*;
#(
  parameter  int NUM_PORTS = 2,
  localparam int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     rr_ptr,
  input  logic                 mode,
  output logic [IDX_W-1:0]     idx
);

  logic             found;
  int               base;
  logic [IDX_W-1:0] cand;

  // Fixed priority is a round-robin scan that always starts at port 0.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    base  = mode ? int'(rr_ptr) : 0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = IDX_W'(wrap_idx(base, k, NUM_PORTS));
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - N-to-1 pipelined Wishbone arbiter with grant held per bus cycle
module wb_arbiter
  import ecap5_dproc_pkg::*;
#(
  parameter int NUM_PORTS       = 2,
  parameter int ARB_MODE        = ARB_FIXED,
  parameter int MAX_OUTSTANDING = 4
) (
  input logic         clk_i,
  input logic         rst_i,
  wb_arbiter_if.slave bus
);

  localparam int               IDX_W     = $clog2(NUM_PORTS);
  localparam int               CNT_W     = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_OUTSTANDING);
  localparam logic [IDX_W-1:0] LAST_PORT = IDX_W'(NUM_PORTS - 1);

  arb_state_t           state_q, state_d;
  logic [IDX_W-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     pick;
  logic [NUM_PORTS-1:0] req;
  logic                 busy;
  logic                 at_limit;
  logic                 accept;
  logic                 ack_dec;

  assign req      = bus.s_wb_cyc_i & bus.s_wb_stb_i;
  assign busy     = (state_q == ARB_BUSY);
  assign at_limit = (cnt_q == CNT_MAX);

  wb_arbiter_picker #(
    .NUM_PORTS(NUM_PORTS)
  ) u_picker (
    .req   (req),
    .rr_ptr(rr_ptr_q),
    .mode  (ARB_MODE == ARB_RR),
    .idx   (pick)
  );

  always_comb begin
    bus.m_wb_adr_o   = bus.s_wb_adr_i[grant_q];
    bus.m_wb_dat_o   = bus.s_wb_dat_i[grant_q];
    bus.m_wb_we_o    = bus.s_wb_we_i[grant_q];
    bus.m_wb_sel_o   = bus.s_wb_sel_i[grant_q];
    bus.m_wb_cyc_o   = busy & bus.s_wb_cyc_i[grant_q];
    bus.m_wb_stb_o   = busy & bus.s_wb_stb_i[grant_q] & ~at_limit;
    bus.s_wb_stall_o = '1;
    bus.s_wb_ack_o   = '0;
    bus.s_wb_dat_o   = '0;
    if (busy) begin
      bus.s_wb_stall_o[grant_q] = bus.m_wb_stall_i | at_limit;
      bus.s_wb_ack_o[grant_q]   = bus.m_wb_ack_i;
      bus.s_wb_dat_o[grant_q]   = bus.m_wb_dat_i;
    end
  end

  // Acks arriving with nothing in flight are not counted, so the counter cannot wrap.
  assign accept  = bus.m_wb_stb_o & ~bus.m_wb_stall_i;
  assign ack_dec = busy & bus.m_wb_ack_i & (cnt_q != '0);

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    case ({accept, ack_dec})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    case (state_q)
      ARB_IDLE: begin
        if (|req) begin
          grant_d = pick;
          state_d = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (!bus.s_wb_cyc_i[grant_q]) begin
          state_d = ARB_IDLE;
          cnt_d   = '0;
          if (ARB_MODE == ARB_RR) begin
            rr_ptr_d = (grant_q == LAST_PORT) ? '0 : grant_q + 1'b1;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ARB_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - self-checking bench for wb_arbiter, fixed and round-robin instances
module tb_wb_arbiter;
  import ecap5_dproc_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];

  wb_arbiter_if #(.NUM_PORTS(3)) f_bus ();
  wb_arbiter_if #(.NUM_PORTS(3)) r_bus ();

  wb_arbiter #(
    .NUM_PORTS      (3),
    .ARB_MODE       (ARB_FIXED),
    .MAX_OUTSTANDING(2)
  ) u_fix (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (f_bus)
  );

  wb_arbiter #(
    .NUM_PORTS      (3),
    .ARB_MODE       (ARB_RR),
    .MAX_OUTSTANDING(2)
  ) u_rr (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (r_bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic init_bus();
    rst = 1'b1;
    f_bus.s_wb_cyc_i = '0; f_bus.s_wb_stb_i = '0;
    r_bus.s_wb_cyc_i = '0; r_bus.s_wb_stb_i = '0;
    f_bus.m_wb_dat_i = '0; f_bus.m_wb_ack_i = 1'b0; f_bus.m_wb_stall_i = 1'b0;
    r_bus.m_wb_dat_i = '0; r_bus.m_wb_ack_i = 1'b0; r_bus.m_wb_stall_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      f_bus.s_wb_adr_i[i] = 32'h1000 + 32'(i);
      f_bus.s_wb_dat_i[i] = 32'hA000 + 32'(i);
      f_bus.s_wb_sel_i[i] = 4'(i + 1);
      f_bus.s_wb_we_i[i]  = i[0];
      r_bus.s_wb_adr_i[i] = 32'h2000 + 32'(i);
      r_bus.s_wb_dat_i[i] = 32'hB000 + 32'(i);
      r_bus.s_wb_sel_i[i] = 4'hF;
      r_bus.s_wb_we_i[i]  = 1'b0;
    end
  endtask

  task automatic test_reset();
    f_bus.s_wb_cyc_i = '1;
    f_bus.s_wb_stb_i = '1;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (f_bus.m_wb_cyc_o !== 1'b0 || f_bus.m_wb_stb_o !== 1'b0) begin
        n_err++; $display("FAIL reset_master: cyc=%b stb=%b want 0 0", f_bus.m_wb_cyc_o, f_bus.m_wb_stb_o);
      end
      n_cmp++;
      if (f_bus.s_wb_stall_o !== 3'b111 || f_bus.s_wb_ack_o !== 3'b000) begin
        n_err++; $display("FAIL reset_stall: stall=%b ack=%b want 111 000", f_bus.s_wb_stall_o, f_bus.s_wb_ack_o);
      end
      n_cmp++;
      if (r_bus.s_wb_stall_o !== 3'b111 || r_bus.m_wb_cyc_o !== 1'b0) begin
        n_err++; $display("FAIL reset_rr: stall=%b cyc=%b want 111 0", r_bus.s_wb_stall_o, r_bus.m_wb_cyc_o);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (f_bus.m_wb_cyc_o !== 1'b1 || f_bus.m_wb_stb_o !== 1'b1 || f_bus.m_wb_adr_o !== 32'h1000) begin
      n_err++; $display("FAIL reset_first_grant: cyc=%b stb=%b adr=%h want 1 1 00001000",
                        f_bus.m_wb_cyc_o, f_bus.m_wb_stb_o, f_bus.m_wb_adr_o);
    end
    n_cmp++;
    if (f_bus.s_wb_stall_o !== 3'b110 || f_bus.s_wb_dat_o !== '0) begin
      n_err++; $display("FAIL reset_first_stall: stall=%b dat=%h want 110 0", f_bus.s_wb_stall_o, f_bus.s_wb_dat_o);
    end
    f_bus.s_wb_cyc_i = '0;
    f_bus.s_wb_stb_i = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_fixed_priority();
    f_bus.s_wb_cyc_i = 3'b110;
    f_bus.s_wb_stb_i = 3'b110;
    @(negedge clk);
    n_cmp++;
    if (f_bus.m_wb_adr_o !== 32'h1001 || f_bus.s_wb_stall_o !== 3'b101) begin
      n_err++; $display("FAIL fixed_grant: adr=%h stall=%b want 00001001 101", f_bus.m_wb_adr_o, f_bus.s_wb_stall_o);
    end
    n_cmp++;
    if (f_bus.m_wb_dat_o !== 32'hA001 || f_bus.m_wb_sel_o !== 4'h2 || f_bus.m_wb_we_o !== 1'b1) begin
      n_err++; $display("FAIL fixed_mirror: dat=%h sel=%h we=%b want 0000a001 2 1",
                        f_bus.m_wb_dat_o, f_bus.m_wb_sel_o, f_bus.m_wb_we_o);
    end
    f_bus.s_wb_stb_i = 3'b101;
    f_bus.s_wb_cyc_i = 3'b111;
    repeat (2) begin
      @(negedge clk);
      n_cmp++;
      if (f_bus.m_wb_adr_o !== 32'h1001 || f_bus.s_wb_stall_o !== 3'b101 || f_bus.m_wb_cyc_o !== 1'b1) begin
        n_err++; $display("FAIL fixed_hold: adr=%h stall=%b cyc=%b want 00001001 101 1",
                          f_bus.m_wb_adr_o, f_bus.s_wb_stall_o, f_bus.m_wb_cyc_o);
      end
    end
    f_bus.s_wb_cyc_i = 3'b100;
    f_bus.s_wb_stb_i = 3'b100;
    @(negedge clk);
    n_cmp++;
    if (f_bus.m_wb_cyc_o !== 1'b0 || f_bus.s_wb_stall_o !== 3'b111) begin
      n_err++; $display("FAIL fixed_release: cyc=%b stall=%b want 0 111", f_bus.m_wb_cyc_o, f_bus.s_wb_stall_o);
    end
    @(negedge clk);
    n_cmp++;
    if (f_bus.m_wb_adr_o !== 32'h1002 || f_bus.s_wb_stall_o !== 3'b011 || f_bus.m_wb_cyc_o !== 1'b1) begin
      n_err++; $display("FAIL fixed_second: adr=%h stall=%b cyc=%b want 00001002 011 1",
                        f_bus.m_wb_adr_o, f_bus.s_wb_stall_o, f_bus.m_wb_cyc_o);
    end
    f_bus.s_wb_cyc_i = '0;
    f_bus.s_wb_stb_i = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_round_robin();
    int          ptr;
    int          p;
    bit          got;
    logic [31:0] e;
    ptr = 0;
    r_bus.s_wb_cyc_i = 3'b111;
    r_bus.s_wb_stb_i = 3'b111;
    for (int n = 0; n < 6; n++) begin
      exp_q.push_back(32'(ptr));
      ptr = (ptr + 1) % 3;
    end
    for (int n = 0; n < 6; n++) begin
      got = 1'b0;
      for (int t = 0; t < 10; t++) begin
        @(negedge clk);
        if (r_bus.m_wb_cyc_o === 1'b1) begin
          got = 1'b1;
          break;
        end
      end
      e = exp_q.pop_front();
      n_cmp++;
      if (!got) begin
        n_err++; $display("FAIL rr_timeout: no grant seen, want port %0d", e);
        continue;
      end
      p = int'(r_bus.m_wb_adr_o - 32'h2000);
      if (p !== int'(e)) begin
        n_err++; $display("FAIL rr_order: beat %0d granted port %0d want %0d", n, p, e);
      end
      if (p < 0 || p > 2) p = 0;
      @(negedge clk);
      r_bus.m_wb_ack_i    = 1'b1;
      r_bus.s_wb_cyc_i[p] = 1'b0;
      r_bus.s_wb_stb_i[p] = 1'b0;
      #1;
      n_cmp++;
      if (r_bus.s_wb_ack_o !== 3'(1 << p)) begin
        n_err++; $display("FAIL rr_ack_at_release: ack=%b want %b", r_bus.s_wb_ack_o, 3'(1 << p));
      end
      @(negedge clk);
      r_bus.m_wb_ack_i    = 1'b0;
      r_bus.s_wb_cyc_i[p] = 1'b1;
      r_bus.s_wb_stb_i[p] = 1'b1;
    end
    r_bus.s_wb_cyc_i = '0;
    r_bus.s_wb_stb_i = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_outstanding();
    f_bus.m_wb_stall_i  = 1'b0;
    f_bus.s_wb_cyc_i[0] = 1'b1;
    f_bus.s_wb_stb_i[0] = 1'b1;
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      n_cmp++;
      if (f_bus.m_wb_stb_o !== 1'b1 || f_bus.s_wb_stall_o[0] !== 1'b0) begin
        n_err++; $display("FAIL os_beat%0d: stb=%b stall0=%b want 1 0", b, f_bus.m_wb_stb_o, f_bus.s_wb_stall_o[0]);
      end
    end
    repeat (2) begin
      @(negedge clk);
      n_cmp++;
      if (f_bus.m_wb_stb_o !== 1'b0 || f_bus.s_wb_stall_o[0] !== 1'b1) begin
        n_err++; $display("FAIL os_block: stb=%b stall0=%b want 0 1", f_bus.m_wb_stb_o, f_bus.s_wb_stall_o[0]);
      end
    end
    f_bus.m_wb_ack_i = 1'b1;
    #1;
    n_cmp++;
    if (f_bus.s_wb_ack_o !== 3'b001) begin
      n_err++; $display("FAIL os_ack_fwd: ack=%b want 001", f_bus.s_wb_ack_o);
    end
    @(negedge clk);
    f_bus.m_wb_ack_i = 1'b0;
    n_cmp++;
    if (f_bus.m_wb_stb_o !== 1'b1 || f_bus.s_wb_stall_o[0] !== 1'b0) begin
      n_err++; $display("FAIL os_third: stb=%b stall0=%b want 1 0", f_bus.m_wb_stb_o, f_bus.s_wb_stall_o[0]);
    end
    @(negedge clk);
    n_cmp++;
    if (f_bus.m_wb_stb_o !== 1'b0 || f_bus.s_wb_stall_o[0] !== 1'b1) begin
      n_err++; $display("FAIL os_after_third: stb=%b stall0=%b want 0 1", f_bus.m_wb_stb_o, f_bus.s_wb_stall_o[0]);
    end
    f_bus.s_wb_cyc_i[0] = 1'b0;
    f_bus.s_wb_stb_i[0] = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (f_bus.m_wb_cyc_o !== 1'b0 || f_bus.s_wb_stall_o !== 3'b111 || u_fix.cnt_q !== 2'd0) begin
      n_err++; $display("FAIL abort_idle: cyc=%b stall=%b cnt=%0d want 0 111 0",
                        f_bus.m_wb_cyc_o, f_bus.s_wb_stall_o, u_fix.cnt_q);
    end
    f_bus.m_wb_ack_i = 1'b1;
    #1;
    n_cmp++;
    if (f_bus.s_wb_ack_o !== 3'b000) begin
      n_err++; $display("FAIL abort_stray_ack: ack=%b want 000", f_bus.s_wb_ack_o);
    end
    @(negedge clk);
    f_bus.m_wb_ack_i    = 1'b0;
    f_bus.s_wb_cyc_i[0] = 1'b1;
    f_bus.s_wb_stb_i[0] = 1'b1;
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      n_cmp++;
      if (f_bus.m_wb_stb_o !== (b < 2)) begin
        n_err++; $display("FAIL abort_regrant_beat%0d: stb=%b want %b", b, f_bus.m_wb_stb_o, (b < 2));
      end
    end
    f_bus.s_wb_cyc_i = '0;
    f_bus.s_wb_stb_i = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_read_routing();
    logic [31:0] e;
    f_bus.s_wb_cyc_i[1] = 1'b1;
    f_bus.s_wb_stb_i[1] = 1'b1;
    @(negedge clk);
    f_bus.s_wb_stb_i[1] = 1'b0;
    f_bus.m_wb_dat_i    = 32'hDEADBEEF;
    f_bus.m_wb_ack_i    = 1'b1;
    exp_q.push_back(32'hDEADBEEF);
    #1;
    e = exp_q.pop_front();
    n_cmp++;
    if (f_bus.s_wb_dat_o[1] !== e) begin
      n_err++; $display("FAIL rd_port1: dat=%h want %h", f_bus.s_wb_dat_o[1], e);
    end
    n_cmp++;
    if (f_bus.s_wb_dat_o[0] !== 32'h0 || f_bus.s_wb_dat_o[2] !== 32'h0) begin
      n_err++; $display("FAIL rd_others: dat0=%h dat2=%h want 0 0", f_bus.s_wb_dat_o[0], f_bus.s_wb_dat_o[2]);
    end
    n_cmp++;
    if (f_bus.s_wb_ack_o !== 3'b010) begin
      n_err++; $display("FAIL rd_ack: ack=%b want 010", f_bus.s_wb_ack_o);
    end
    @(negedge clk);
    f_bus.m_wb_ack_i    = 1'b0;
    f_bus.s_wb_cyc_i[1] = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (f_bus.s_wb_dat_o !== '0) begin
      n_err++; $display("FAIL rd_idle_zero: dat=%h want 0", f_bus.s_wb_dat_o);
    end
    f_bus.m_wb_dat_i = '0;
    @(negedge clk);
  endtask

  initial begin
    init_bus();
    test_reset();
    test_fixed_priority();
    test_round_robin();
    test_outstanding();
    test_read_routing();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
